lc3_regfile_sb: RTL and testbench

Parametrised register file for the pipelined LC-3 core: NREGS x DATA_W storage, three combinational read ports, one writeback port, optional write-to-read bypass, and a per-register pending-write scoreboard. Decode allocates destinations at issue; writeback releases them. Hazard logic uses rd_busy* to stall. Sits between decode/issue and the writeback stage.

---
 rtl/lc3_pkg.sv | 30 +++
 rtl/lc3_regfile_sb_if.sv | 47 ++++
 rtl/lc3_scoreboard.sv | 84 ++++++++
 rtl/lc3_regfile_sb.sv | 78 +++++++
 tb/tb_lc3_regfile_sb.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared LC-3 core definitions: default datapath sizes, fixed register indices
// used by decode for implicit destinations, and the DR/SR1 mux encodings.
// -----------------------------------------------------------------------------
package lc3_pkg;

    localparam int LC3_DATA_W = 16;
    localparam int LC3_NREGS  = 8;

    // Implicit destinations: R6 is the stack pointer, R7 the link register
    // (JSR/JSRR/TRAP/interrupt entry allocate these).
    localparam logic [2:0] R6_SP = 3'd6;
    localparam logic [2:0] R7_LR = 3'd7;

    // Destination-register mux select.
    typedef enum logic [1:0] {
        DRMUX_IR11_9 = 2'd0,
        DRMUX_R7     = 2'd1,
        DRMUX_R6     = 2'd2
    } drmux_e;

    // Source-register-1 mux select.
    typedef enum logic [1:0] {
        SR1MUX_IR11_9 = 2'd0,
        SR1MUX_IR8_6  = 2'd1,
        SR1MUX_R6     = 2'd2
    } sr1mux_e;

endpackage

// File: rtl/lc3_regfile_sb_if.sv
// -----------------------------------------------------------------------------
// lc3_regfile_sb_if
// Bundle between decode/issue/writeback (master) and the register file with
// scoreboard (slave).
//   rd_addr0/1/2, rd_data0/1/2, rd_busy0/1/2 : three read ports + hazard flags
//   alloc_en, alloc_addr, alloc_ready        : destination reservation at issue
//   wr_en, wr_addr, wr_data                  : writeback port
//   flush                                    : drop all reservations
//   wb_orphan                                : sticky unmatched-writeback flag
// -----------------------------------------------------------------------------
interface lc3_regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
);
    logic [AW-1:0]     rd_addr0, rd_addr1, rd_addr2;
    logic [DATA_W-1:0] rd_data0, rd_data1, rd_data2;
    logic              rd_busy0, rd_busy1, rd_busy2;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic              alloc_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              wb_orphan;

    modport master (
        output rd_addr0, rd_addr1, rd_addr2,
        input  rd_data0, rd_data1, rd_data2,
        input  rd_busy0, rd_busy1, rd_busy2,
        output alloc_en, alloc_addr,
        input  alloc_ready,
        output wr_en, wr_addr, wr_data, flush,
        input  wb_orphan
    );

    modport slave (
        input  rd_addr0, rd_addr1, rd_addr2,
        output rd_data0, rd_data1, rd_data2,
        output rd_busy0, rd_busy1, rd_busy2,
        input  alloc_en, alloc_addr,
        output alloc_ready,
        input  wr_en, wr_addr, wr_data, flush,
        output wb_orphan
    );
endinterface

// File: rtl/lc3_scoreboard.sv
// -----------------------------------------------------------------------------
// lc3_scoreboard
// Per-register saturating pending-write counters.
//   clk, rst          : clock, async active-low reset
//   alloc_en_i/addr_i : reservation request; alloc_ready_o gates acceptance
//   wr_en_i/addr_i    : writeback; releases one reservation if any is held
//   flush_i           : zero every counter (wins over same-cycle alloc/release)
//   rd_addr_i[3]      : read-port indices
//   rd_busy_o[3]      : indexed counter non-zero
//   rd_last_o[3]      : indexed counter == 1 (lets the top apply bypass)
//   wb_orphan_o       : sticky, set by a writeback to a zero counter
// -----------------------------------------------------------------------------
module lc3_scoreboard
    import lc3_pkg::*;
#(
    parameter int NREGS  = LC3_NREGS,
    parameter int PEND_W = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_en_i,
    input  logic [AW-1:0] alloc_addr_i,
    output logic          alloc_ready_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          flush_i,
    input  logic [AW-1:0] rd_addr_i [3],
    output logic [2:0]    rd_busy_o,
    output logic [2:0]    rd_last_o,
    output logic          wb_orphan_o
);
    localparam logic [PEND_W-1:0] MAXP = '1;
    localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);

    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic              orphan_q, orphan_d;
    logic              alloc_ok, wr_live, inc, dec;

    assign alloc_ready_o = (pend_q[alloc_addr_i] != MAXP);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        alloc_ok = alloc_en_i && alloc_ready_o;
        wr_live  = wr_en_i && (pend_q[wr_addr_i] != '0);
        inc      = 1'b0;
        dec      = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            inc       = alloc_ok && (alloc_addr_i == AW'(r));
            dec       = wr_live && (wr_addr_i == AW'(r));
            pend_d[r] = pend_q[r];
            if (flush_i)
                pend_d[r] = '0;
            else if (inc && !dec)
                pend_d[r] = pend_q[r] + ONE;   // alloc_ready blocks inc at MAXP
            else if (dec && !inc)
                pend_d[r] = pend_q[r] - ONE;   // dec requires a non-zero count
        end
        // A writeback landing in the flush cycle is expected, not orphaned.
        orphan_d = orphan_q || (wr_en_i && (pend_q[wr_addr_i] == '0) && !flush_i);
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_busy_o[i] = (pend_q[rd_addr_i[i]] != '0);
            rd_last_o[i] = (pend_q[rd_addr_i[i]] == ONE);
        end
    end

    assign wb_orphan_o = orphan_q;

    // NOTE: sequential state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
            orphan_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: rtl/lc3_regfile_sb.sv
// -----------------------------------------------------------------------------
// lc3_regfile_sb
// LC-3 register file: NREGS x DATA_W storage, three combinational read ports,
// one writeback port, optional same-cycle writeback bypass (FWD), and a
// pending-write scoreboard (lc3_scoreboard).
//   clk, rst : clock, async active-low reset
//   bus      : lc3_regfile_sb_if slave modport (reads, alloc, writeback, flush)
// -----------------------------------------------------------------------------
module lc3_regfile_sb
    import lc3_pkg::*;
#(
    parameter int DATA_W = LC3_DATA_W,
    parameter int NREGS  = LC3_NREGS,
    parameter int AW     = $clog2(NREGS),
    parameter int PEND_W = 2,
    parameter int FWD    = 1
) (
    input  logic             clk,
    input  logic             rst,
    lc3_regfile_sb_if.slave  bus
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [AW-1:0]     rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];
    logic [2:0]        sb_busy, sb_last, rd_busy;

    assign rd_addr[0] = bus.rd_addr0;
    assign rd_addr[1] = bus.rd_addr1;
    assign rd_addr[2] = bus.rd_addr2;

    // NOTE: the register array is reset because reads after reset must return zero; it cannot map to a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (bus.wr_en) begin
            regs_q[bus.wr_addr] <= bus.wr_data;   // written regardless of scoreboard state
        end
    end

    lc3_scoreboard #(
        .NREGS  (NREGS),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .alloc_en_i    (bus.alloc_en),
        .alloc_addr_i  (bus.alloc_addr),
        .alloc_ready_o (bus.alloc_ready),
        .wr_en_i       (bus.wr_en),
        .wr_addr_i     (bus.wr_addr),
        .flush_i       (bus.flush),
        .rd_addr_i     (rd_addr),
        .rd_busy_o     (sb_busy),
        .rd_last_o     (sb_last),
        .wb_orphan_o   (bus.wb_orphan)
    );

    // Bypass: a matching writeback supplies the data, and if it retires the
    // last outstanding write the reader need not stall.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_data[i] = regs_q[rd_addr[i]];
            rd_busy[i] = sb_busy[i];
            if ((FWD != 0) && bus.wr_en && (bus.wr_addr == rd_addr[i])) begin
                rd_data[i] = bus.wr_data;
                rd_busy[i] = sb_busy[i] && !sb_last[i];
            end
        end
    end

    assign bus.rd_data0 = rd_data[0];
    assign bus.rd_data1 = rd_data[1];
    assign bus.rd_data2 = rd_data[2];
    assign bus.rd_busy0 = rd_busy[0];
    assign bus.rd_busy1 = rd_busy[1];
    assign bus.rd_busy2 = rd_busy[2];

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_lc3_regfile_sb
// Directed bench for lc3_regfile_sb: a FWD=1 instance carries most vectors,
// a FWD=0 instance covers the no-bypass read timing.
// -----------------------------------------------------------------------------
module tb_lc3_regfile_sb;
    import lc3_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lc3_regfile_sb_if #(.DATA_W(16), .NREGS(8)) b  ();
    lc3_regfile_sb_if #(.DATA_W(16), .NREGS(8)) b0 ();

    lc3_regfile_sb #(.DATA_W(16), .NREGS(8), .PEND_W(2), .FWD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    lc3_regfile_sb #(.DATA_W(16), .NREGS(8), .PEND_W(2), .FWD(0)) dut_nofwd (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        b.alloc_en  = 1'b0; b.alloc_addr = '0;
        b.wr_en     = 1'b0; b.wr_addr    = '0; b.wr_data = '0;
        b.flush     = 1'b0;
        b0.alloc_en = 1'b0; b0.alloc_addr = '0;
        b0.wr_en    = 1'b0; b0.wr_addr    = '0; b0.wr_data = '0;
        b0.flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        b.rd_addr0 = a0; b.rd_addr1 = a1; b.rd_addr2 = a2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        set_rd(3'd0, 3'd3, 3'd7);
        b0.rd_addr0 = '0; b0.rd_addr1 = '0; b0.rd_addr2 = '0;

        // Reset state
        #2;
        check("rst_data0", b.rd_data0, 16'h0000);
        check("rst_data1", b.rd_data1, 16'h0000);
        check("rst_data2", b.rd_data2, 16'h0000);
        check("rst_busy", {b.rd_busy0, b.rd_busy1, b.rd_busy2}, 3'b000);
        check("rst_ready", b.alloc_ready, 1'b1);
        check("rst_orphan", b.wb_orphan, 1'b0);
        #5 rst = 1'b1;
        tick();

        // Alloc R2, then writeback with bypass
        b.alloc_en = 1'b1; b.alloc_addr = 3'd2;
        tick();
        idle();
        set_rd(3'd2, 3'd0, 3'd0);
        #1 check("r2_busy_after_alloc", b.rd_busy0, 1'b1);
        b.wr_en = 1'b1; b.wr_addr = 3'd2; b.wr_data = 16'h1234;
        #1;
        check("r2_bypass_data", b.rd_data0, 16'h1234);
        check("r2_bypass_busy", b.rd_busy0, 1'b0);
        tick();
        idle();
        #1;
        check("r2_data_after_wb", b.rd_data0, 16'h1234);
        check("r2_busy_after_wb", b.rd_busy0, 1'b0);

        // R7 saturation: three allocs accepted, fourth rejected
        set_rd(3'd0, R7_LR, 3'd0);
        for (int k = 0; k < 3; k++) begin
            b.alloc_en = 1'b1; b.alloc_addr = R7_LR;
            #1 check($sformatf("r7_ready_%0d", k), b.alloc_ready, 1'b1);
            tick();
        end
        #1 check("r7_ready_full", b.alloc_ready, 1'b0);
        tick();
        // Alloc + writeback at MAXP: alloc rejected, count drops to 2
        b.wr_en = 1'b1; b.wr_addr = R7_LR; b.wr_data = 16'h7000;
        #1 check("r7_ready_full_wb", b.alloc_ready, 1'b0);
        tick();
        idle();
        b.alloc_addr = R7_LR;
        #1;
        check("r7_ready_pend2", b.alloc_ready, 1'b1);
        check("r7_busy_pend2", b.rd_busy1, 1'b1);
        b.wr_en = 1'b1; b.wr_addr = R7_LR; b.wr_data = 16'h7001;
        #1 check("r7_busy_wb_pend2", b.rd_busy1, 1'b1);
        tick();
        b.wr_data = 16'h7002;
        #1 check("r7_busy_wb_pend1", b.rd_busy1, 1'b0);
        tick();
        idle();
        #1;
        check("r7_busy_drained", b.rd_busy1, 1'b0);
        check("r7_data", b.rd_data1, 16'h7002);
        check("no_orphan_yet", b.wb_orphan, 1'b0);

        // R5: simultaneous alloc + writeback at pend 1 keeps the count
        set_rd(3'd0, 3'd0, 3'd5);
        b.alloc_en = 1'b1; b.alloc_addr = 3'd5;
        tick();
        b.wr_en = 1'b1; b.wr_addr = 3'd5; b.wr_data = 16'hBEEF;
        #1 check("r5_bypass_busy", b.rd_busy2, 1'b0);
        tick();
        idle();
        #1;
        check("r5_busy_kept", b.rd_busy2, 1'b1);
        check("r5_data", b.rd_data2, 16'hBEEF);
        b.wr_en = 1'b1; b.wr_addr = 3'd5; b.wr_data = 16'hBEEF;
        tick();
        idle();
        #1 check("r5_busy_drained", b.rd_busy2, 1'b0);

        // Flush with same-cycle writeback, then orphan writeback
        set_rd(3'd1, 3'd4, 3'd5);
        b.alloc_en = 1'b1; b.alloc_addr = 3'd1;
        tick();
        b.alloc_addr = 3'd4;
        tick();
        idle();
        #1 check("pre_flush_busy", {b.rd_busy0, b.rd_busy1}, 2'b11);
        b.flush = 1'b1; b.wr_en = 1'b1; b.wr_addr = 3'd1; b.wr_data = 16'h00FF;
        tick();
        idle();
        #1;
        check("flush_busy", {b.rd_busy0, b.rd_busy1, b.rd_busy2}, 3'b000);
        check("flush_r1_data", b.rd_data0, 16'h00FF);
        check("flush_orphan", b.wb_orphan, 1'b0);
        b.wr_en = 1'b1; b.wr_addr = 3'd4; b.wr_data = 16'h4444;
        tick();
        idle();
        #1 check("orphan_set", b.wb_orphan, 1'b1);
        tick();
        tick();
        check("orphan_sticky", b.wb_orphan, 1'b1);
        check("orphan_r4_data", b.rd_data1, 16'h4444);

        // Mid-traffic reset
        b.alloc_en = 1'b1; b.alloc_addr = R6_SP;
        tick();
        set_rd(3'd1, 3'd5, 3'd7);
        b.wr_en = 1'b1; b.wr_addr = 3'd0; b.wr_data = 16'h5555;
        #1 rst = 1'b0;
        #1;
        check("mrst_data0", b.rd_data0, 16'h0000);
        check("mrst_data1", b.rd_data1, 16'h0000);
        check("mrst_data2", b.rd_data2, 16'h0000);
        check("mrst_orphan", b.wb_orphan, 1'b0);
        b.rd_addr0 = R6_SP;
        #1;
        check("mrst_busy_r6", b.rd_busy0, 1'b0);
        check("mrst_ready_r6", b.alloc_ready, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        b.rd_addr1 = 3'd0;
        #1;
        check("mrst_wr_discarded", b.rd_data1, 16'h0000);
        check("mrst_alloc_discarded", b.rd_busy0, 1'b0);

        // FWD=0 instance: no same-cycle bypass of data or busy
        tick();
        b0.rd_addr0 = 3'd3;
        b0.alloc_en = 1'b1; b0.alloc_addr = 3'd3;
        tick();
        idle();
        b0.wr_en = 1'b1; b0.wr_addr = 3'd3; b0.wr_data = 16'hAAAA;
        #1;
        check("nofwd_old_data", b0.rd_data0, 16'h0000);
        check("nofwd_busy_during_wb", b0.rd_busy0, 1'b1);
        tick();
        idle();
        #1;
        check("nofwd_new_data", b0.rd_data0, 16'hAAAA);
        check("nofwd_busy_after", b0.rd_busy0, 1'b0);
        check("nofwd_orphan", b0.wb_orphan, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
